// File: rtl/ncl_tx_pkg.sv
// Shared types and default parameters for the NCL dual-rail transmitter.
package ncl_tx_pkg;

    localparam int unsigned W_DEF           = 4;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned TMO_CYCLES_DEF  = 255;

    typedef enum logic [1:0] {
        S_NULLW = 2'd0,
        S_IDLE  = 2'd1,
        S_DATA  = 2'd2
    } state_t;

endpackage

// File: rtl/ncl_sync.sv
// Parameterized-depth flop chain synchronizer with async active-low clear.
module ncl_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rsb,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rsb) begin
        if (!rsb) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ncl_sync_tx.sv
// Single-rail to NCL dual-rail transmitter driven by a synchronized ko handshake.
// Optional sticky handshake watchdog with err output: define NCL_TX_TIMEOUT_EN.
module ncl_sync_tx
    import ncl_tx_pkg::*;
#(
    parameter int unsigned W           = W_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned TMO_CYCLES  = TMO_CYCLES_DEF
) (
    input  logic         clk,
    input  logic         rsb,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         ko,
    output logic [W-1:0] dr_t,
    output logic [W-1:0] dr_f,
    output logic         busy
`ifdef NCL_TX_TIMEOUT_EN
    ,
    output logic         err
`endif
);

    state_t       state_q;
    state_t       state_d;
    logic         ko_s;
    logic         accept;
    logic [W-1:0] word_q;

    ncl_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ko_sync (
        .clk (clk),
        .rsb (rsb),
        .d   (ko),
        .q   (ko_s)
    );

    assign in_ready = (state_q == S_IDLE) && ko_s;
    assign busy     = (state_q != S_IDLE);
    assign accept   = in_valid && in_ready;

    // Wavefront sequencing: NULL must be acknowledged before the next DATA.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_NULLW: if (ko_s)   state_d = S_IDLE;
            S_IDLE:  if (accept) state_d = S_DATA;
            S_DATA:  if (!ko_s)  state_d = S_NULLW;
            default:             state_d = S_NULLW;
        endcase
    end

    // Rails are loaded from the next state so they are plain flop outputs.
    always_ff @(posedge clk or negedge rsb) begin
        if (!rsb) begin
            state_q <= S_NULLW;
            word_q  <= '0;
            dr_t    <= '0;
            dr_f    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                word_q <= in_data;
                dr_t   <= in_data;
                dr_f   <= ~in_data;
            end else if (state_d != S_DATA) begin
                dr_t   <= '0;
                dr_f   <= '0;
            end
        end
    end

`ifdef NCL_TX_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TMO_CYCLES + 1) > 0 ? $clog2(TMO_CYCLES + 1) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Cycles spent waiting on ko in one wavefront phase, saturating at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q != S_IDLE) && (cnt_q != CW'(TMO_CYCLES))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rsb) begin
        if (!rsb) begin
            cnt_q <= '0;
            err   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (cnt_d == CW'(TMO_CYCLES)) begin
                err <= 1'b1;
            end
        end
    end
`endif

endmodule
